// File: rtl/posit_unit_arbiter_if.sv
// Bundle between the requesters, the shared posit unit and the arbiter.
// The arbiter connects through the slave modport; requesters plus the unit connect through master.
interface posit_unit_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ*2-1:0]     req_op;
   logic                   unit_valid;
   logic [WIDTH-1:0]       unit_a;
   logic [WIDTH-1:0]       unit_b;
   logic [1:0]             unit_op;
   logic                   unit_res_valid;
   logic [WIDTH-1:0]       unit_res;
   logic [N_REQ-1:0]       rsp_valid;
   logic [N_REQ*WIDTH-1:0] rsp_data;
   logic [N_REQ-1:0]       rsp_ready;
   logic                   busy;
   logic                   err_protocol;

   modport slave (
      input  req_valid, req_a, req_b, req_op, unit_res_valid, unit_res, rsp_ready,
      output req_ready, unit_valid, unit_a, unit_b, unit_op, rsp_valid, rsp_data,
             busy, err_protocol
   );

   modport master (
      output req_valid, req_a, req_b, req_op, unit_res_valid, unit_res, rsp_ready,
      input  req_ready, unit_valid, unit_a, unit_b, unit_op, rsp_valid, rsp_data,
             busy, err_protocol
   );
endinterface

// File: rtl/posit_unit_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined posit unit among N_REQ requesters.
// A tag pipeline tracks each issued op so its result lands in the owner's response register.
module posit_unit_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 32,
   parameter int UNIT_LAT = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   posit_unit_arbiter_if.slave bus
);
   localparam int TW = $clog2(N_REQ);
   localparam logic [TW:0] N_EXT = (TW+1)'(N_REQ);

   logic [TW-1:0]    rr_ptr_reg;
   logic [TW-1:0]    rr_ptr_next;
   logic [N_REQ-1:0] outstanding_reg;
   logic [N_REQ-1:0] outstanding_next;
   logic [N_REQ-1:0] rsp_valid_reg;
   logic [N_REQ-1:0] rsp_valid_next;
   logic [WIDTH-1:0] rsp_data_reg [N_REQ];
   logic             unit_valid_reg;
   logic [WIDTH-1:0] unit_a_reg;
   logic [WIDTH-1:0] unit_b_reg;
   logic [1:0]       unit_op_reg;
   logic [TW-1:0]    issue_tag_reg;
   logic [UNIT_LAT-1:0] tag_valid_reg;
   logic [TW-1:0]    tag_reg [UNIT_LAT];
   logic             err_reg;

   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] rsp_hs;
   logic [N_REQ-1:0] res_wr;
   logic             grant_any;
   logic [TW-1:0]    grant_idx;
   logic [TW:0]      cand;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [1:0]       sel_op;
   logic             res_hit;
   logic [TW-1:0]    res_tag;

   assign elig = bus.req_valid & ~outstanding_reg;

   // Scan rr_ptr, rr_ptr+1, ... modulo N_REQ; first eligible index wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_reg} + (TW+1)'(k);
         if (cand >= N_EXT) cand = cand - N_EXT;
         if (!grant_any && elig[cand[TW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[TW-1:0];
         end
      end
   end

   // Gated by rst_n so the grant reads zero while reset is held.
   always_comb begin
      grant = '0;
      if (grant_any && rst_n) grant[grant_idx] = 1'b1;
   end

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_idx == TW'(k)) begin
            sel_a  = bus.req_a[k*WIDTH +: WIDTH];
            sel_b  = bus.req_b[k*WIDTH +: WIDTH];
            sel_op = bus.req_op[k*2 +: 2];
         end
      end
   end

   assign rr_ptr_next = !grant_any ? rr_ptr_reg :
                        (grant_idx == TW'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
   assign res_tag     = tag_reg[UNIT_LAT-1];
   assign res_hit     = bus.unit_res_valid & tag_valid_reg[UNIT_LAT-1];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign rsp_hs[gi]           = rsp_valid_reg[gi] & bus.rsp_ready[gi];
      assign res_wr[gi]           = res_hit && (res_tag == TW'(gi));
      assign outstanding_next[gi] = grant[gi] | (outstanding_reg[gi] & ~rsp_hs[gi]);
      assign rsp_valid_next[gi]   = res_wr[gi] | (rsp_valid_reg[gi] & ~rsp_hs[gi]);
      assign bus.rsp_data[gi*WIDTH +: WIDTH] = rsp_data_reg[gi];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg      <= '0;
         outstanding_reg <= '0;
         rsp_valid_reg   <= '0;
         unit_valid_reg  <= 1'b0;
         unit_a_reg      <= '0;
         unit_b_reg      <= '0;
         unit_op_reg     <= '0;
         issue_tag_reg   <= '0;
         tag_valid_reg   <= '0;
         err_reg         <= 1'b0;
         for (int k = 0; k < UNIT_LAT; k++) tag_reg[k] <= '0;
         for (int k = 0; k < N_REQ; k++) rsp_data_reg[k] <= '0;
      end else begin
         rr_ptr_reg      <= rr_ptr_next;
         outstanding_reg <= outstanding_next;
         rsp_valid_reg   <= rsp_valid_next;
         unit_valid_reg  <= grant_any;
         if (grant_any) begin
            unit_a_reg    <= sel_a;
            unit_b_reg    <= sel_b;
            unit_op_reg   <= sel_op;
            issue_tag_reg <= grant_idx;
         end
         tag_valid_reg[0] <= unit_valid_reg;
         tag_reg[0]       <= issue_tag_reg;
         for (int k = 1; k < UNIT_LAT; k++) begin
            tag_valid_reg[k] <= tag_valid_reg[k-1];
            tag_reg[k]       <= tag_reg[k-1];
         end
         // Either a result with no owner or an owner with no result breaks the fixed-latency contract.
         if (bus.unit_res_valid != tag_valid_reg[UNIT_LAT-1]) err_reg <= 1'b1;
         for (int k = 0; k < N_REQ; k++) begin
            if (res_wr[k]) rsp_data_reg[k] <= bus.unit_res;
         end
      end
   end

   assign bus.req_ready    = grant;
   assign bus.unit_valid   = unit_valid_reg;
   assign bus.unit_a       = unit_a_reg;
   assign bus.unit_b       = unit_b_reg;
   assign bus.unit_op      = unit_op_reg;
   assign bus.rsp_valid    = rsp_valid_reg;
   assign bus.busy         = |outstanding_reg;
   assign bus.err_protocol = err_reg;
endmodule

// File: tb/tb_posit_unit_arbiter.sv
// Directed bench for posit_unit_arbiter with a mock 3-stage unit sharing rst_n.
// Mock result = a ^ b ^ op ^ 0x44000000, so expected results are hand-derivable.
module tb_posit_unit_arbiter;
   localparam int N_REQ    = 4;
   localparam int WIDTH    = 32;
   localparam int UNIT_LAT = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic spur;
   always #5 clk = ~clk;

   posit_unit_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   posit_unit_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .UNIT_LAT(UNIT_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   logic [UNIT_LAT-1:0] mv;
   logic [WIDTH-1:0]    md [UNIT_LAT];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv <= '0;
         for (int k = 0; k < UNIT_LAT; k++) md[k] <= '0;
      end else begin
         mv    <= {mv[UNIT_LAT-2:0], bus.unit_valid};
         md[0] <= bus.unit_a ^ bus.unit_b ^ {30'b0, bus.unit_op} ^ 32'h44000000;
         for (int k = 1; k < UNIT_LAT; k++) md[k] <= md[k-1];
      end
   end
   assign bus.unit_res_valid = mv[UNIT_LAT-1] | spur;
   assign bus.unit_res       = spur ? 32'h12345678 : md[UNIT_LAT-1];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rsp_slice(input int i);
      return bus.rsp_data[i*WIDTH +: WIDTH];
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
      bus.req_op[i*2 +: 2]        = op;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"},  64'(bus.req_ready), 64'd0);
      chk({tag, "_unit_valid"}, 64'(bus.unit_valid), 64'd0);
      chk({tag, "_unit_a"},     64'(bus.unit_a), 64'd0);
      chk({tag, "_unit_b"},     64'(bus.unit_b), 64'd0);
      chk({tag, "_unit_op"},    64'(bus.unit_op), 64'd0);
      chk({tag, "_rsp_valid"},  64'(bus.rsp_valid), 64'd0);
      chk({tag, "_rsp_data"},   64'(|bus.rsp_data), 64'd0);
      chk({tag, "_busy"},       64'(bus.busy), 64'd0);
      chk({tag, "_err"},        64'(bus.err_protocol), 64'd0);
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while (bus.busy && k < 30) begin
         step();
         k++;
      end
      chk(name, 64'(bus.busy), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  req_valid;
      logic [3:0]  rsp_ready;
      logic [3:0]  exp_ready;
      logic        exp_uv;
      logic [31:0] exp_a;
      logic [3:0]  exp_rsp;
      logic        exp_busy;
   } vec_t;

   vec_t        vecs [12];
   logic [31:0] exp_res [4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int others;
      vecs[0]  = '{4'hF, 4'hF, 4'b0001, 1'b0, 32'h00000000, 4'b0000, 1'b0};
      vecs[1]  = '{4'hF, 4'hF, 4'b0010, 1'b1, 32'h10000000, 4'b0000, 1'b1};
      vecs[2]  = '{4'hF, 4'hF, 4'b0100, 1'b1, 32'h20000000, 4'b0000, 1'b1};
      vecs[3]  = '{4'hF, 4'hF, 4'b1000, 1'b1, 32'h30000000, 4'b0000, 1'b1};
      vecs[4]  = '{4'hF, 4'hF, 4'b0000, 1'b1, 32'h40000000, 4'b0000, 1'b1};
      vecs[5]  = '{4'hF, 4'hF, 4'b0000, 1'b0, 32'h40000000, 4'b0001, 1'b1};
      vecs[6]  = '{4'hF, 4'hF, 4'b0001, 1'b0, 32'h40000000, 4'b0010, 1'b1};
      vecs[7]  = '{4'hF, 4'hF, 4'b0010, 1'b1, 32'h10000000, 4'b0100, 1'b1};
      vecs[8]  = '{4'hF, 4'hF, 4'b0100, 1'b1, 32'h20000000, 4'b1000, 1'b1};
      vecs[9]  = '{4'hF, 4'hF, 4'b1000, 1'b1, 32'h30000000, 4'b0000, 1'b1};
      vecs[10] = '{4'hF, 4'hF, 4'b0000, 1'b1, 32'h40000000, 4'b0000, 1'b1};
      vecs[11] = '{4'hF, 4'hF, 4'b0000, 1'b0, 32'h40000000, 4'b0001, 1'b1};
      exp_res[0] = 32'h55000000;
      exp_res[1] = 32'h66000001;
      exp_res[2] = 32'h77000002;
      exp_res[3] = 32'h00000003;

      rst_n = 1'b0;
      spur = 1'b0;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_op = '0;
      bus.rsp_ready = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // Single requester end to end.
      step();
      set_req(0, 32'h40000000, 32'h50000000, 2'd0);
      bus.req_valid = 4'b0001;
      #1;
      chk("t1_ready_c1", 64'(bus.req_ready), 64'b0001);
      chk("t1_uv_c1", 64'(bus.unit_valid), 64'd0);
      step();
      bus.req_valid = 4'b0000;
      #1;
      chk("t1_uv_c2", 64'(bus.unit_valid), 64'd1);
      chk("t1_unit_a", 64'(bus.unit_a), 64'h40000000);
      chk("t1_unit_b", 64'(bus.unit_b), 64'h50000000);
      chk("t1_unit_op", 64'(bus.unit_op), 64'd0);
      for (int c = 3; c <= 5; c++) begin
         step();
         chk($sformatf("t1_rsp_c%0d", c), 64'(bus.rsp_valid), 64'd0);
      end
      step();
      chk("t1_rsp_c6", 64'(bus.rsp_valid), 64'b0001);
      chk("t1_data_c6", 64'(rsp_slice(0)), 64'h54000000);
      $display("t1: rsp_valid=%b rsp_data0=0x%h", bus.rsp_valid, rsp_slice(0));
      step();
      chk("t1_rsp_hold", 64'(bus.rsp_valid), 64'b0001);
      bus.rsp_ready = 4'b0001;
      step();
      chk("t1_rsp_clr", 64'(bus.rsp_valid), 64'd0);
      chk("t1_busy_clr", 64'(bus.busy), 64'd0);

      // Table: all four requesting from reset with rsp_ready high.
      for (int i = 0; i < 4; i++)
         set_req(i, 32'(i+1) << 28, 32'(i+1) << 24, 2'(i));
      do_reset();
      for (int r = 0; r < 12; r++) begin
         if (r != 0) step();
         bus.req_valid = vecs[r].req_valid;
         bus.rsp_ready = vecs[r].rsp_ready;
         #1;
         chk($sformatf("t2_ready_%0d", r), 64'(bus.req_ready), 64'(vecs[r].exp_ready));
         chk($sformatf("t2_uv_%0d", r), 64'(bus.unit_valid), 64'(vecs[r].exp_uv));
         chk($sformatf("t2_unit_a_%0d", r), 64'(bus.unit_a), 64'(vecs[r].exp_a));
         chk($sformatf("t2_rsp_%0d", r), 64'(bus.rsp_valid), 64'(vecs[r].exp_rsp));
         chk($sformatf("t2_busy_%0d", r), 64'(bus.busy), 64'(vecs[r].exp_busy));
         for (int i = 0; i < 4; i++)
            if (vecs[r].exp_rsp[i])
               chk($sformatf("t2_data_%0d_%0d", r, i), 64'(rsp_slice(i)), 64'(exp_res[i]));
         $display("vec %0d: req_ready=%b unit_valid=%b unit_a=0x%h rsp_valid=%b busy=%b",
                  r, bus.req_ready, bus.unit_valid, bus.unit_a, bus.rsp_valid, bus.busy);
      end
      bus.req_valid = 4'b0000;
      wait_idle("t2_drain");

      // Move rr_ptr to 2, then req_valid=1011 must grant 3, 0, 1.
      step();
      bus.req_valid = 4'b0010;
      #1;
      chk("t3_setup", 64'(bus.req_ready), 64'b0010);
      step();
      bus.req_valid = 4'b0000;
      wait_idle("t3_setup_drain");
      step();
      bus.req_valid = 4'b1011;
      #1;
      chk("t3_grant3", 64'(bus.req_ready), 64'b1000);
      step();
      chk("t3_grant0", 64'(bus.req_ready), 64'b0001);
      chk("t3_unit_a3", 64'(bus.unit_a), 64'h40000000);
      chk("t3_unit_op3", 64'(bus.unit_op), 64'd3);
      step();
      chk("t3_grant1", 64'(bus.req_ready), 64'b0010);
      step();
      chk("t3_none", 64'(bus.req_ready), 64'd0);
      $display("t3: grant sequence checked");
      bus.req_valid = 4'b0000;
      wait_idle("t3_drain");

      // Requester 1 stalls its response for 10 cycles.
      step();
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 4'b1101;
      begin
         int k;
         k = 0;
         while (!bus.rsp_valid[1] && k < 20) begin
            step();
            k++;
         end
      end
      chk("t4_rsp1_seen", 64'(bus.rsp_valid[1]), 64'd1);
      chk("t4_data1", 64'(rsp_slice(1)), 64'h66000001);
      others = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("t4_hold_valid_%0d", c), 64'(bus.rsp_valid[1]), 64'd1);
         chk($sformatf("t4_hold_data_%0d", c), 64'(rsp_slice(1)), 64'h66000001);
         chk($sformatf("t4_no_regrant_%0d", c), 64'(bus.req_ready[1]), 64'd0);
         if ((bus.req_ready & 4'b1101) != 0) others++;
      end
      chk("t4_others_served", 64'(others > 0), 64'd1);
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 4'b1111;
      #1;
      chk("t4_same_cycle", 64'(bus.req_ready[1]), 64'd0);
      step();
      chk("t4_regrant", 64'(bus.req_ready), 64'b0010);
      chk("t4_rsp1_clr", 64'(bus.rsp_valid[1]), 64'd0);
      $display("t4: requester 1 re-granted after response consumed");
      step();
      bus.req_valid = 4'b0000;
      wait_idle("t4_drain");

      // NaR is routed like any other value.
      step();
      set_req(2, 32'h80000000, 32'h44000000, 2'd0);
      bus.req_valid = 4'b0100;
      #1;
      chk("t5_ready", 64'(bus.req_ready), 64'b0100);
      step();
      bus.req_valid = 4'b0000;
      #1;
      chk("t5_unit_a", 64'(bus.unit_a), 64'h80000000);
      for (int c = 2; c <= 4; c++) begin
         step();
         chk($sformatf("t5_rsp_c%0d", c), 64'(bus.rsp_valid), 64'd0);
      end
      step();
      chk("t5_rsp", 64'(bus.rsp_valid), 64'b0100);
      chk("t5_data", 64'(rsp_slice(2)), 64'h80000000);
      $display("t5: rsp_valid=%b rsp_data2=0x%h", bus.rsp_valid, rsp_slice(2));
      wait_idle("t5_drain");

      // Spurious result, then reset with two ops in flight.
      chk("t6_err_before", 64'(bus.err_protocol), 64'd0);
      step();
      spur = 1'b1;
      step();
      spur = 1'b0;
      #1;
      chk("t6_err_set", 64'(bus.err_protocol), 64'd1);
      chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
      repeat (3) step();
      chk("t6_err_held", 64'(bus.err_protocol), 64'd1);
      set_req(0, 32'h11111111, 32'h22222222, 2'd1);
      set_req(1, 32'h33333333, 32'h44444444, 2'd2);
      bus.req_valid = 4'b0011;
      step();
      step();
      chk("t6_in_flight", 64'(bus.busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("t6_rst");
      bus.req_valid = 4'b0000;
      repeat (2) step();
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         chk($sformatf("t6_post_rsp_%0d", c), 64'(bus.rsp_valid), 64'd0);
         chk($sformatf("t6_post_err_%0d", c), 64'(bus.err_protocol), 64'd0);
      end
      $display("t6: reset discarded in-flight ops");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
